// File: rtl/scan_sequencer_3b.sv
// Timed channel scanner producing the 3-bit select for a 3-to-8 one-hot decoder.
// Define SCAN_SEQ_SKIP_EN to honour chan_mask; otherwise all 8 channels are visited.
module scan_sequencer_3b #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         chan_mask,
    output logic [2:0]         sel_out,
    output logic               sel_valid,
    output logic               busy,
    output logic               done,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [7:0]         mask_q, mask_d;
    logic               valid_q, done_q;
    logic [7:0]         eff_mask;
    logic [7:0]         above;

`ifdef SCAN_SEQ_SKIP_EN
    assign eff_mask = chan_mask;
`else
    logic unused_mask;
    assign unused_mask = ^chan_mask;
    assign eff_mask    = 8'hFF;
`endif

    function automatic logic [2:0] lowest_idx(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Enabled channels strictly above the current one; empty means end of pass.
    assign above = mask_q & (8'hFE << sel_q);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d  = eff_mask;
                    dwell_d = dwell;
                    cnt_d   = '0;
                    if (eff_mask != 8'd0) begin
                        state_d = SCAN;
                        sel_d   = lowest_idx(eff_mask);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SCAN: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == dwell_q) begin
                    cnt_d = '0;
                    if (above != 8'd0) begin
                        sel_d = lowest_idx(above);
                    end else if (loop) begin
                        sel_d = lowest_idx(mask_q);
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mask_q  <= 8'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            valid_q <= (state_d == SCAN);
            done_q  <= (state_d == DONE);
        end
    end

    assign sel_out   = sel_q;
    assign sel_valid = valid_q;
    assign busy      = valid_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule
